// File: rtl/core_types_pkg.sv
// Shared sizing for the branch-target upper-PC store.
// The BTB keeps low target bits plus an index into this table.
package core_types_pkg;
    localparam int UPPER_PC_TABLE_ENTRIES = 8;
    localparam int UPPER_PC_WIDTH         = 19;
    localparam int LOG_UPT_ENTRIES        = 3;

    typedef logic [LOG_UPT_ENTRIES-1:0] upt_index_t;
    typedef logic [6:0]                 plru8_state_t;
endpackage

// File: rtl/plru8_tree.sv
// 8-way tree pseudo-LRU: 7-bit state, victim walk, and two touches per cycle.
// Touch A is applied before touch B, so B owns any node both paths share.
module plru8_tree
    import core_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       touch_a_valid,
    input  upt_index_t touch_a_index,
    input  logic       touch_b_valid,
    input  upt_index_t touch_b_index,
    output upt_index_t victim
);
    plru8_state_t plru, plru_mid, plru_next;

    // Each node on the touched path is pointed away from the touched leaf.
    function automatic plru8_state_t touch(input plru8_state_t s, input upt_index_t i);
        plru8_state_t r;
        logic [2:0]   n1, n2;
        r     = s;
        n1    = 3'd1 + {2'b00, i[2]};
        n2    = 3'd3 + {1'b0, i[2:1]};
        r[0]  = ~i[2];
        r[n1] = ~i[1];
        r[n2] = ~i[0];
        return r;
    endfunction

    always_comb begin
        plru_mid  = touch_a_valid ? touch(plru, touch_a_index) : plru;
        plru_next = touch_b_valid ? touch(plru_mid, touch_b_index) : plru_mid;
    end

    logic [2:0] vn1, vn2;
    always_comb begin
        vn1       = 3'd1 + {2'b00, plru[0]};
        vn2       = 3'd3 + {1'b0, plru[0], plru[vn1]};
        victim    = {plru[0], plru[vn1], plru[vn2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) plru <= '0;
        else     plru <= plru_next;
    end
endmodule

// File: rtl/upper_pc_table.sv
// Upper-PC store: decodes BTB indices back to PC[31:13] and encodes resolved
// targets into an existing or freshly allocated index.
module upper_pc_table #(
    parameter int UPPER_PC_TABLE_ENTRIES = core_types_pkg::UPPER_PC_TABLE_ENTRIES,
    parameter int UPPER_PC_WIDTH         = core_types_pkg::UPPER_PC_WIDTH,
    parameter int LOG_UPT_ENTRIES        = core_types_pkg::LOG_UPT_ENTRIES
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       read_valid_in,
    input  logic [LOG_UPT_ENTRIES-1:0] read_index_in,
    output logic [UPPER_PC_WIDTH-1:0]  read_upper_PC_out,
    input  logic                       update0_valid_in,
    input  logic [31:0]                update0_target_full_PC_in,
    output logic                       update1_valid_out,
    output logic [LOG_UPT_ENTRIES-1:0] update1_upper_PC_index_out,
    output logic                       update1_hit_out
);
    localparam int PC_LO = 32 - UPPER_PC_WIDTH;

    logic [UPPER_PC_WIDTH-1:0]         entry [UPPER_PC_TABLE_ENTRIES];
    logic [UPPER_PC_TABLE_ENTRIES-1:0] valid;
    logic [UPPER_PC_TABLE_ENTRIES-1:0] match;
    logic [UPPER_PC_WIDTH-1:0]         upper;
    logic                              hit;
    logic [LOG_UPT_ENTRIES-1:0]        hit_index, free_index, victim, chosen;
    logic                              unused_low_bits;

    assign upper           = update0_target_full_PC_in[31:PC_LO];
    assign unused_low_bits = ^update0_target_full_PC_in[PC_LO-1:0];

    // CAM compare over valid entries plus lowest-free priority encode.
    always_comb begin
        match      = '0;
        hit_index  = '0;
        free_index = '0;
        for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++)
            match[i] = valid[i] && (entry[i] == upper);
        for (int i = UPPER_PC_TABLE_ENTRIES - 1; i >= 0; i--) begin
            if (match[i])  hit_index  = LOG_UPT_ENTRIES'(i);
            if (!valid[i]) free_index = LOG_UPT_ENTRIES'(i);
        end
    end

    assign hit = |match;

    always_comb begin
        chosen = free_index;
        if (hit)         chosen = hit_index;
        else if (&valid) chosen = victim;
    end

    plru8_tree u_plru (
        .clk           (CLK),
        .rst           (RST),
        .touch_a_valid (read_valid_in),
        .touch_a_index (read_index_in),
        .touch_b_valid (update0_valid_in),
        .touch_b_index (chosen),
        .victim        (victim)
    );

    // The read samples entry[] before this edge's write lands: no bypass.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++) entry[i] <= '0;
            valid                      <= '0;
            read_upper_PC_out          <= '0;
            update1_valid_out          <= 1'b0;
            update1_upper_PC_index_out <= '0;
            update1_hit_out            <= 1'b0;
        end else begin
            update1_valid_out <= update0_valid_in;
            if (read_valid_in) read_upper_PC_out <= entry[read_index_in];
            if (update0_valid_in) begin
                update1_upper_PC_index_out <= chosen;
                update1_hit_out            <= hit;
                if (!hit) begin
                    entry[chosen] <= upper;
                    valid[chosen] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_upper_pc_table.sv
// Randomized + directed bench for upper_pc_table with a queue scoreboard.
// Reference model tracks per-entry last-touch times; the tree victim is derived from them.
module tb_upper_pc_table;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        read_valid_in = 1'b0;
    logic [2:0]  read_index_in = '0;
    logic [18:0] read_upper_PC_out;
    logic        update0_valid_in = 1'b0;
    logic [31:0] update0_target_full_PC_in = '0;
    logic        update1_valid_out;
    logic [2:0]  update1_upper_PC_index_out;
    logic        update1_hit_out;

    upper_pc_table dut (
        .CLK                        (CLK),
        .RST                        (RST),
        .read_valid_in              (read_valid_in),
        .read_index_in              (read_index_in),
        .read_upper_PC_out          (read_upper_PC_out),
        .update0_valid_in           (update0_valid_in),
        .update0_target_full_PC_in  (update0_target_full_PC_in),
        .update1_valid_out          (update1_valid_out),
        .update1_upper_PC_index_out (update1_upper_PC_index_out),
        .update1_hit_out            (update1_hit_out)
    );

    always #5 CLK = ~CLK;

    typedef struct { int idx; bit hit; } upd_exp_t;

    upd_exp_t upd_q[$];
    int       rd_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;

    // Reference model: table contents and a per-entry "last touched" time.
    int       m_entry [8];
    bit       m_valid [8];
    longint   m_ts    [8];
    longint   m_tick;

    logic     rd_pend;
    always @(posedge CLK or posedge RST)
        if (RST) rd_pend <= 1'b0;
        else     rd_pend <= read_valid_in;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint max_ts(input int lo, input int n);
        longint m = 0;
        for (int i = lo; i < lo + n; i++) if (m_ts[i] > m) m = m_ts[i];
        return m;
    endfunction

    // Each level steers away from whichever half saw the most recent touch.
    function automatic int model_victim();
        int lo = 0;
        for (int size = 8; size > 1; size /= 2) begin
            if (max_ts(lo, size / 2) > max_ts(lo + size / 2, size / 2)) lo += size / 2;
        end
        return lo;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_entry[i] = 0; m_valid[i] = 0; m_ts[i] = 0;
        end
        m_tick = 0;
        upd_q.delete();
        rd_q.delete();
    endtask

    // Drive one cycle of stimulus and push the model's expected responses.
    task automatic cyc(input bit rv, input int ridx, input bit uv, input logic [31:0] tgt);
        int       upper;
        upd_exp_t e;
        @(posedge CLK); #1;
        read_valid_in             = rv;
        read_index_in             = 3'(ridx);
        update0_valid_in          = uv;
        update0_target_full_PC_in = tgt;
        if (rv) rd_q.push_back(m_entry[ridx]);
        e.idx = 0; e.hit = 0;
        if (uv) begin
            upper = int'(tgt >> 13);
            for (int i = 0; i < 8; i++)
                if (m_valid[i] && m_entry[i] == upper) begin e.hit = 1; e.idx = i; end
            if (!e.hit) begin
                e.idx = -1;
                for (int i = 7; i >= 0; i--) if (!m_valid[i]) e.idx = i;
                if (e.idx < 0) e.idx = model_victim();
            end
            upd_q.push_back(e);
        end
        m_tick++;
        if (rv) m_ts[ridx] = m_tick;
        m_tick++;
        if (uv) begin
            m_ts[e.idx] = m_tick;
            if (!e.hit) begin
                m_entry[e.idx] = int'(tgt >> 13);
                m_valid[e.idx] = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0);
    endtask

    // Asserts reset before the next capture edge, so an in-flight request is dropped.
    task automatic do_reset();
        #3;
        RST = 1'b1;
        #1;
        chk("rst_upd_valid", update1_valid_out, 0);
        chk("rst_upd_index", update1_upper_PC_index_out, 0);
        chk("rst_upd_hit", update1_hit_out, 0);
        chk("rst_read_out", read_upper_PC_out, 0);
        read_valid_in    = 1'b0;
        update0_valid_in = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        model_reset();
        RST = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result; otherwise checks hold.
    initial begin
        int       last_rd;
        upd_exp_t last_u, e;
        last_rd = 0; last_u.idx = 0; last_u.hit = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                last_rd = 0; last_u.idx = 0; last_u.hit = 0;
            end else begin
                if (update1_valid_out) begin
                    if (upd_q.size() == 0) chk("upd_unexpected", 1, 0);
                    else begin
                        e = upd_q.pop_front();
                        chk("upd_index", update1_upper_PC_index_out, e.idx);
                        chk("upd_hit", update1_hit_out, e.hit);
                        last_u = e;
                    end
                end else begin
                    chk("upd_hold_index", update1_upper_PC_index_out, last_u.idx);
                    chk("upd_hold_hit", update1_hit_out, last_u.hit);
                end
                if (rd_pend) begin
                    if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                    else begin
                        last_rd = rd_q.pop_front();
                        chk("read_data", read_upper_PC_out, last_rd);
                    end
                end else chk("read_hold", read_upper_PC_out, last_rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Reset allocation, then a hit on the same upper bits with different low bits.
        cyc(0, 0, 1, 32'h0000_2000);
        cyc(0, 0, 1, 32'h0000_2FFE);
        idle(2);

        // Fill order, second copies hit, then tree replacement with a concurrent read.
        do_reset();
        for (int n = 1; n <= 8; n++) cyc(0, 0, 1, 32'(n) << 13);
        for (int n = 1; n <= 8; n++) cyc(0, 0, 1, 32'(n) << 13);
        cyc(0, 0, 1, 32'(9) << 13);
        cyc(1, 1, 1, 32'(10) << 13);
        idle(2);

        // Read-before-write on index 3, then read again to see the new value.
        do_reset();
        for (int n = 1; n <= 3; n++) cyc(0, 0, 1, 32'(n) << 13);
        cyc(1, 3, 1, 32'hFFFF_E000);
        cyc(1, 3, 0, 32'h0);
        idle(2);

        // Back-to-back duplicate encode must hit on the second.
        cyc(0, 0, 1, 32'(32'h12345) << 13);
        cyc(0, 0, 1, (32'(32'h12345) << 13) | 32'h1ABC);
        idle(2);

        // Reset while an encode is in flight; the next encode reallocates index 0.
        cyc(1, 2, 1, 32'hDEAD_B000);
        do_reset();
        cyc(0, 0, 1, 32'h0123_4000);
        idle(2);

        // Random traffic over a small pool so hits, fills and replacements all occur.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            logic [31:0] tgt;
            tgt = ((32'h40 + 32'($urandom_range(0, 11))) << 13) | 32'($urandom_range(0, 8191));
            cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), tgt);
        end
        idle(3);
        chk("upd_queue_drained", upd_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/upper_pc_table.md
# upper_pc_table

Shared upper-PC store for the branch-target path. The BTB keeps only the low 12 target bits plus a 3-bit upper-PC index. This block performs both halves of that split:
- **Decode (read side):** resolves an index back into the upper target bits for the fetch predictor.
- **Encode (update side):** finds or allocates the index that represents a full target PC.

It sits beside the BTB banks, on the predictor fetch path and on the branch-resolution update path.

## Interface
Parameters:
- UPPER_PC_TABLE_ENTRIES, 8: table entries; must be a power of 2, fixed at 8 for the tree PLRU below.
- UPPER_PC_WIDTH, 19: upper PC bits stored, PC[31:13].
- LOG_UPT_ENTRIES, 3: index width.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- read_valid_in  in  1  fetch predictor read request.
- read_index_in  in  3  upper-PC index from the BTB entry.
- read_upper_PC_out  out  19  upper target bits for the previous cycle's read.
- update0_valid_in  in  1  encode request.
- update0_target_full_PC_in  in  32  resolved branch target.
- update1_valid_out  out  1  encode result valid.
- update1_upper_PC_index_out  out  3  index now holding target[31:13].
- update1_hit_out  out  1  1 = existing entry matched, 0 = entry allocated.

## Operation
State:
- entry[0..7] of 19 bits.
- valid[7:0].
- plru[6:0] tree.

Encode (cycle t, update0_valid_in=1): compare upper = target[31:13] against all valid entries.
- **Hit:** chosen index = matching index (at most one match is possible). Table is unchanged.
- **Miss, some entry invalid:** chosen index = lowest invalid index. At the edge, set entry ← upper and valid ← 1.
- **Miss, all valid:** chosen index = PLRU victim. Same write at the edge.
- Overwriting an entry silently retargets every BTB entry that references it. This is accepted; the resulting mispredicts are corrected by the BRU.

Decode (cycle t, read_valid_in=1): at the edge, read_upper_PC_out ← entry[read_index_in].
- valid bits are ignored on reads; an invalid entry returns its stored bits.
- When read_valid_in=0, read_upper_PC_out holds its value.

PLRU layout (node 0 = root, nodes 1–2 = halves, nodes 3–6 = pairs):
- Bit = 0 means "victim on the left / lower indices".
- Touching index i sets: plru[0] ← ~i[2]; plru[1+i[2]] ← ~i[1]; plru[3+i[2:1]] ← ~i[0].

PLRU touches:
- A read touches read_index_in.
- An encode touches the chosen index.
- Both in the same cycle: apply the read touch first, then the encode touch. The encode touch wins on shared nodes.

Simultaneous read and write to the same index: the read returns the old value (read-before-write). No bypass.

## Timing
- Read latency: 1 cycle, registered, matching BTB SRAM latency.
- Encode latency: 1 cycle.
  - update1_valid_out is update0_valid_in delayed by one cycle.
  - update1_upper_PC_index_out and update1_hit_out are registered with it; they hold their values when update1_valid_out=0.
- Back-to-back encodes: the table write at edge t is visible to the compare at t+1. An identical upper value at t+1 must hit, with no duplicate allocation.
- No backpressure; one encode and one read accepted per cycle.
- Reset values: all outputs 0; entry[*]=0; valid=0; plru=0.
- RST asserted at any time, including mid-encode, clears state immediately. A request pending at reset is dropped: update1_valid_out=0 after reset.

## Structure
- Shared package (core_types_pkg) holds UPPER_PC_TABLE_ENTRIES, UPPER_PC_WIDTH and LOG_UPT_ENTRIES.
- Natural sub-module: plru8_tree, which contains the 7-bit state, victim computation and dual-touch update.
- CAM compare and the invalid priority encoder stay inline.

## Test plan
- **Reset allocation:** reset, then encode 0x0000_2000 → next cycle update1_valid_out=1, index=0, hit=0. Encode 0x0000_2FFE → index=0, hit=1.
- **Fill order:** encode upper values 1..8 (target = n<<13) in consecutive cycles → indices 0..7, all hit=0. The second copy of each → matching index, hit=1.
- **PLRU replacement:** after filling 0..7 in order with no reads, encode upper 9 → index 0. Then read index 1 and encode upper 10 in the same cycle → victim comes from entries 4..7 (index 4).
- **Read-before-write:** allocate upper 0x7FFFF into index 3 at cycle t while reading index 3 at t → read_upper_PC_out shows the old value at t+1. Reading again at t+1 → 0x7FFFF at t+2.
- **Back-to-back duplicate:** encode upper 0x12345 at t and at t+1 → first result hit=0, second hit=1, same index; only one valid bit set.
- **Reset mid-encode:** assert RST one cycle after update0_valid_in → all outputs 0, and the next encode allocates index 0.
